// File: rtl/serial_sub4_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_sub4_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_sub4_bit_cell.sv
// One-bit subtract cell: sum/carry of a + ~b + cin.
module sub_bit_cell
   import serial_sub4_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic b_inv;

   assign b_inv = ~b;
   assign sum   = a ^ b_inv ^ cin;
   assign cout  = (a & b_inv) | (a & cin) | (b_inv & cin);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial a - b (a + ~b + 1), LSB first, one bit per clock, with borrow and signed overflow.
module serial_sub4
   import serial_sub4_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)(
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;

   logic             cell_sum;
   logic             cell_cout;
   logic [WIDTH-1:0] res_shifted;

   sub_bit_cell u_cell (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .sum  (cell_sum),
      .cout (cell_cout)
   );

   // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
   assign res_shifted = (res_q >> 1) | (WIDTH'(cell_sum) << (WIDTH - 1));

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = 1'b1;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            res_d   = res_shifted;
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = cell_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               // carry_q is the carry into the MSB here; compare it with the carry out.
               diff_d   = res_shifted;
               borrow_d = ~cell_cout;
               ovf_d    = carry_q ^ cell_cout;
               state_d  = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign diff   = diff_q;
   assign borrow = borrow_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_sub4.sv
// Randomized and directed bench for serial_sub4 with a queue scoreboard and arithmetic reference model.
module tb_serial_sub4;

   localparam int W = 4;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         borrow;
      logic         ovf;
   } exp_t;

   logic         clk;
   logic         resetn;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
   logic         ovf;

   int   checks;
   int   failures;
   int   cycle;
   int   done_count;
   int   n_expected;
   bit   sweep_mode;
   bit   have_prev;
   int   prev_done;
   exp_t exp_q[$];

   serial_sub4 #(.WIDTH(W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   // Reference: plain integer subtraction, unsigned compare, signed range test.
   function automatic exp_t ref_sub(int ai, int bi);
      exp_t e;
      int   sa, sb, r;
      e.diff   = W'((ai - bi) & ((1 << W) - 1));
      e.borrow = (ai < bi);
      sa       = (ai >= (1 << (W - 1))) ? ai - (1 << W) : ai;
      sb       = (bi >= (1 << (W - 1))) ? bi - (1 << W) : bi;
      r        = sa - sb;
      e.ovf    = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
      return e;
   endfunction

   task automatic check(string name, int act, int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard on every done pulse.
   always @(negedge clk) begin
      if (resetn && done) begin
         exp_t e;
         done_count++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done with empty scoreboard at cycle %0d", cycle);
         end else begin
            e = exp_q.pop_front();
            checks++;
            if ({diff, borrow, ovf} != {e.diff, e.borrow, e.ovf}) begin
               failures++;
               $display("FAIL result: got diff=%0d borrow=%0d ovf=%0d, expected diff=%0d borrow=%0d ovf=%0d",
                        diff, borrow, ovf, e.diff, e.borrow, e.ovf);
            end else begin
               $display("done cycle=%0d diff=%0d borrow=%0d ovf=%0d", cycle, diff, borrow, ovf);
            end
         end
         if (sweep_mode) begin
            if (have_prev) check("done_spacing", cycle - prev_done, W + 2);
            have_prev = 1'b1;
            prev_done = cycle;
         end else begin
            have_prev = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         tick();
         n++;
      end
      if (busy) check("idle_timeout", 1, 0);
   endtask

   task automatic push(int ai, int bi);
      exp_q.push_back(ref_sub(ai, bi));
      n_expected++;
   endtask

   // Single operation with latency/hold checks; glitch re-pulses start mid-SHIFT with a=b=1.
   task automatic do_op(int ai, int bi, bit glitch);
      exp_t e;
      e = ref_sub(ai, bi);
      wait_idle();
      a     = W'(ai);
      b     = W'(bi);
      start = 1'b1;
      push(ai, bi);
      $display("op a=%0d b=%0d", ai, bi);
      tick();
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      for (int i = 1; i <= W; i++) begin
         if (glitch && i == 1) begin
            a = 1; b = 1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         if (i < W) check("done_early", done, 0);
         else       check("done_latency", done, 1);
      end
      start = 1'b0;
      tick();
      check("busy_after_done", busy, 0);
      check("done_width", done, 0);
      check("diff_hold", diff, e.diff);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      done_count = 0;
      n_expected = 0;
      sweep_mode = 1'b0;
      have_prev  = 1'b0;
      prev_done  = 0;
      resetn     = 1'b0;
      start      = 1'b0;
      a          = '0;
      b          = '0;

      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_diff", diff, 0);
      check("rst_borrow", borrow, 0);
      check("rst_ovf", ovf, 0);
      resetn = 1'b1;
      tick();

      do_op(9, 4, 1'b0);
      do_op(4, 9, 1'b0);
      do_op(7, 8, 1'b0);
      do_op(0, 0, 1'b0);
      do_op(9, 4, 1'b1);
      check("glitch_one_done", done_count, n_expected);

      // Abort mid-SHIFT with an asynchronous reset pulse.
      do_op(9, 4, 1'b0);
      wait_idle();
      a = 7; b = 8; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      resetn = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_diff", diff, 0);
      check("abort_done", done, 0);
      tick();
      resetn = 1'b1;
      for (int i = 0; i < 2 * W; i++) begin
         tick();
         if (done) check("abort_no_done", done, 0);
      end
      check("abort_done_count", done_count, n_expected);
      do_op(12, 3, 1'b0);

      for (int i = 0; i < 20; i++) do_op($urandom_range(0, 15), $urandom_range(0, 15), 1'b0);

      // Exhaustive sweep with start held high throughout.
      wait_idle();
      sweep_mode = 1'b1;
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            wait_idle();
            a     = W'(ai);
            b     = W'(bi);
            start = 1'b1;
            push(ai, bi);
            tick();
         end
      end
      start = 1'b0;
      begin
         int n = 0;
         while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
         end
      end
      tick();
      sweep_mode = 1'b0;
      check("scoreboard_empty", exp_q.size(), 0);
      check("total_dones", done_count, n_expected);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
